// File: rtl/uart_pkg.sv
// Shared constants and elaboration-time helpers for the UART baud path.
// Holds the supported-rate table and the phase-increment calculation.
package uart_pkg;

    localparam int unsigned BAUD_DEFAULT = 9600;
    localparam int unsigned N_BAUDS      = 7;

    typedef enum logic [2:0] {
        BAUD_4800,
        BAUD_9600,
        BAUD_14400,
        BAUD_19200,
        BAUD_38400,
        BAUD_57600,
        BAUD_115200
    } baud_sel_e;

    localparam int unsigned BAUD_LIST [N_BAUDS] = '{
        4800, 9600, 14400, 19200, 38400, 57600, 115200
    };

    function automatic int unsigned baud_rate(input baud_sel_e sel);
        return BAUD_LIST[sel];
    endfunction

    // round(baud*osr*2^acc_w/clk_hz); only ever evaluated on constants
    function automatic logic [63:0] calc_inc(
        input longint unsigned baud,
        input longint unsigned clk_hz,
        input longint unsigned osr,
        input int unsigned     acc_w
    );
        logic [63:0] num;
        num = (baud * osr) << acc_w;
        return (num + clk_hz / 2) / clk_hz;
    endfunction

endpackage

// File: rtl/uart_baud_rom.sv
// Combinational baud -> phase increment lookup built from constants.
// Unsupported rates fall back to the default increment and flag err.
module uart_baud_rom
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned OSR         = 16,
    parameter int unsigned ACC_W       = 32,
    parameter int unsigned BAUD_W      = 17
) (
    input  logic [BAUD_W-1:0] baud,
    output logic [ACC_W-1:0]  inc,
    output logic              err
);

    localparam logic [ACC_W-1:0] INC_DEF =
        ACC_W'(calc_inc(BAUD_DEFAULT, CLK_FREQ_HZ, OSR, ACC_W));

    logic [ACC_W-1:0] inc_tab [N_BAUDS];

    for (genvar i = 0; i < N_BAUDS; i++) begin : g_tab
        localparam int unsigned RATE = baud_rate(baud_sel_e'(i));
        assign inc_tab[i] =
            ACC_W'(calc_inc(RATE, CLK_FREQ_HZ, OSR, ACC_W));
    end

    always_comb begin
        inc = INC_DEF;
        err = 1'b1;
        for (int i = 0; i < N_BAUDS; i++) begin
            if (baud == BAUD_W'(BAUD_LIST[i])) begin
                inc = inc_tab[i];
                err = 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_baud_gen.sv
// DDS baud generator: oversample strobe, bit strobe and baud square wave.
// Rate requests are held pending and applied only on bit boundaries.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned OSR         = 16,
    parameter int unsigned ACC_W       = 32,
    parameter int unsigned BAUD_W      = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [BAUD_W-1:0] baud,
    output logic              os_tick,
    output logic              bit_tick,
    output logic              tx_clk,
    output logic              locked,
    output logic              baud_err
);

    localparam int unsigned CNT_W = $clog2(OSR);
    localparam longint unsigned MAX_OS =
        longint'(baud_rate(BAUD_115200)) * OSR;
    localparam logic [ACC_W-1:0] INC_DEFAULT =
        ACC_W'(calc_inc(BAUD_DEFAULT, CLK_FREQ_HZ, OSR, ACC_W));

    if (OSR < 4 || (OSR % 2) != 0 ||
        MAX_OS >= longint'(CLK_FREQ_HZ / 2)) begin : g_bad_cfg
        $error("uart_baud_gen: unsupported OSR / CLK_FREQ_HZ");
    end

    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  inc;
    logic [ACC_W:0]    sum;
    logic [CNT_W-1:0]  os_cnt;
    logic [CNT_W-1:0]  os_nxt;
    logic [BAUD_W-1:0] pend;
    logic              pend_valid;
    logic              carry;
    logic              bit_wrap;
    logic              accept;
    logic              apply;
    logic [ACC_W-1:0]  rom_inc;
    logic              rom_err;

    uart_baud_rom #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ),
        .OSR        (OSR),
        .ACC_W      (ACC_W),
        .BAUD_W     (BAUD_W)
    ) u_rom (
        .baud(pend),
        .inc (rom_inc),
        .err (rom_err)
    );

    assign sum       = {1'b0, acc} + {1'b0, inc};
    assign carry     = en && sum[ACC_W];
    assign bit_wrap  = carry && (os_cnt == CNT_W'(OSR - 1));
    assign os_nxt    = bit_wrap ? '0 : os_cnt + 1'b1;
    assign cfg_ready = !pend_valid;
    assign accept    = cfg_valid && !pend_valid;
    // without a running, locked rate there is no bit to protect
    assign apply     = pend_valid && (bit_wrap || !en || !locked);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            os_cnt     <= '0;
            os_tick    <= 1'b0;
            bit_tick   <= 1'b0;
            tx_clk     <= 1'b0;
            inc        <= INC_DEFAULT;
            locked     <= 1'b0;
            baud_err   <= 1'b0;
            pend       <= '0;
            pend_valid <= 1'b0;
        end else begin
            if (!en) begin
                acc      <= '0;
                os_cnt   <= '0;
                os_tick  <= 1'b0;
                bit_tick <= 1'b0;
                tx_clk   <= 1'b0;
            end else begin
                acc      <= sum[ACC_W-1:0];
                os_tick  <= carry;
                bit_tick <= bit_wrap;
                if (carry) begin
                    os_cnt <= os_nxt;
                    if (bit_wrap) begin
                        tx_clk <= 1'b1;
                    end else if (os_nxt == CNT_W'(OSR / 2)) begin
                        tx_clk <= 1'b0;
                    end
                end
            end
            if (accept) begin
                pend       <= baud;
                pend_valid <= 1'b1;
            end
            if (apply) begin
                inc        <= rom_inc;
                baud_err   <= rom_err;
                locked     <= 1'b1;
                pend_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_baud_gen.sv
// Randomised and directed bench for uart_baud_gen against a
// cumulative-phase reference model of the baud generator.
module tb_uart_baud_gen;

    localparam int unsigned   ACC_W  = 32;
    localparam int unsigned   BAUD_W = 17;
    localparam int unsigned   OSR    = 16;
    localparam real           CLK_HZ = 50.0e6;
    localparam longint unsigned TWO_W = 64'd1 << ACC_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [BAUD_W-1:0] baud;
    logic              os_tick;
    logic              bit_tick;
    logic              tx_clk;
    logic              locked;
    logic              baud_err;

    uart_baud_gen #(
        .CLK_FREQ_HZ(50_000_000),
        .OSR        (OSR),
        .ACC_W      (ACC_W),
        .BAUD_W     (BAUD_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .baud     (baud),
        .os_tick  (os_tick),
        .bit_tick (bit_tick),
        .tx_clk   (tx_clk),
        .locked   (locked),
        .baud_err (baud_err)
    );

    always #10 clk = ~clk;

    int     n_chk  = 0;
    int     n_fail = 0;
    bit     chk_on = 1'b0;
    longint cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] obs,
                            input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit supported(input int unsigned b);
        int unsigned list [7] = '{4800, 9600, 14400, 19200,
                                  38400, 57600, 115200};
        foreach (list[i]) if (list[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    function automatic longint unsigned inc_of(input int unsigned b);
        real x;
        x = real'(supported(b) ? b : 9600) * OSR * real'(TWO_W) / CLK_HZ;
        return longint'(x);
    endfunction

    // Model: total phase since restart; k = number of os carries so far.
    typedef struct {
        longint unsigned total;
        longint unsigned inc;
        bit              locked;
        bit              err;
        bit              pend;
        int unsigned     pbaud;
        bit              os;
        bit              bt;
        bit              tx;
    } mstate_t;

    function automatic mstate_t model_step(input mstate_t s, input bit r,
        input bit e, input bit cv, input int unsigned b);
        mstate_t n;
        longint unsigned ko, kn;
        bit boundary;
        n = s;
        if (r) begin
            n = '{0, inc_of(9600), 0, 0, 0, 0, 0, 0, 0};
            return n;
        end
        n.os = 0;
        n.bt = 0;
        boundary = 0;
        if (e) begin
            ko = s.total / TWO_W;
            n.total = s.total + s.inc;
            kn = n.total / TWO_W;
            if (kn != ko) begin
                n.os = 1;
                boundary = (kn % OSR) == 0;
                n.bt = boundary;
                n.tx = (kn >= OSR) && ((kn % OSR) < OSR / 2);
            end
        end else begin
            n.total = 0;
            n.tx = 0;
        end
        if (s.pend && (boundary || !e || !s.locked)) begin
            n.inc    = inc_of(s.pbaud);
            n.err    = !supported(s.pbaud);
            n.locked = 1;
            n.pend   = 0;
        end
        if (cv && !s.pend) begin
            n.pend  = 1;
            n.pbaud = b;
        end
        return n;
    endfunction

    mstate_t m;

    always @(posedge clk) m <= model_step(m, rst, en, cfg_valid, baud);

    always @(negedge clk)
        if (chk_on && n_fail < 20)
            check_eq("cycle_outs",
                {os_tick, bit_tick, tx_clk, locked, baud_err, cfg_ready},
                {m.os, m.bt, m.tx, m.locked, m.err, !m.pend});

    function automatic longint clamp(input longint v, input longint lo,
                                     input longint hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_bit(output longint t);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bit_tick && n < 12000);
        if (!bit_tick) check_eq("bit_timeout", bit_tick, 1);
        t = cyc;
    endtask

    task automatic wait_os();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!os_tick && n < 1000);
        if (!os_tick) check_eq("os_timeout", os_tick, 1);
    endtask

    task automatic measure_os(input int cnt, output longint mn,
                              output longint mx);
        longint last;
        mn = 1 << 30;
        mx = 0;
        wait_os();
        last = cyc;
        for (int i = 0; i < cnt; i++) begin
            wait_os();
            if (cyc - last < mn) mn = cyc - last;
            if (cyc - last > mx) mx = cyc - last;
            last = cyc;
        end
    endtask

    task automatic do_cfg(input int unsigned b);
        int n = 0;
        baud = BAUD_W'(b);
        cfg_valid = 1'b1;
        while (!cfg_ready && n < 12000) begin
            @(negedge clk);
            n++;
        end
        if (!cfg_ready) check_eq("cfg_timeout", cfg_ready, 1);
        @(negedge clk);
        cfg_valid = 1'b0;
        baud = BAUD_W'($urandom);
    endtask

    longint mn, mx, b0, b1, b2, b3, c0, exp_first;
    int     hi, lo, nb;

    initial begin
        rst = 1'b1;
        en = 1'b0;
        cfg_valid = 1'b0;
        baud = '0;
        tick(3);
        chk_on = 1'b1;
        check_eq("rst_os_tick", os_tick, 0);
        check_eq("rst_bit_tick", bit_tick, 0);
        check_eq("rst_tx_clk", tx_clk, 0);
        check_eq("rst_locked", locked, 0);
        check_eq("rst_baud_err", baud_err, 0);
        check_eq("rst_cfg_ready", cfg_ready, 1);

        // default 9600 after reset
        rst = 1'b0;
        en = 1'b1;
        measure_os(12, mn, mx);
        check_eq("t1_os_min", mn, 325);
        check_eq("t1_os_max", mx, 326);
        wait_bit(b0);
        wait_bit(b1);
        check_eq("t1_bit_iv", b1 - b0, clamp(b1 - b0, 5208, 5209));
        check_eq("t1_locked", locked, 0);
        check_eq("t1_baud_err", baud_err, 0);

        // 115200 applied immediately while unlocked
        do_cfg(115200);
        check_eq("t2_locked_pre", locked, 0);
        tick(1);
        check_eq("t2_locked", locked, 1);
        measure_os(40, mn, mx);
        check_eq("t2_os_min", mn, 27);
        check_eq("t2_os_max", mx, 28);
        wait_bit(b0);
        hi = tx_clk ? 1 : 0;
        lo = tx_clk ? 0 : 1;
        for (int i = 0; i < OSR - 1; i++) begin
            wait_os();
            if (tx_clk) hi++;
            else lo++;
        end
        check_eq("t2_tx_hi", hi, OSR / 2);
        check_eq("t2_tx_lo", lo, OSR / 2);
        nb = 0;
        repeat (5000) begin
            @(negedge clk);
            if (bit_tick) nb++;
        end
        check_eq("t2_bit_count", nb, clamp(nb, 11, 12));

        // mid-bit switch 9600 -> 57600 waits for the boundary
        do_cfg(9600);
        wait_bit(b0);
        wait_bit(b1);
        tick(1000 + $urandom_range(0, 2000));
        do_cfg(57600);
        check_eq("t3_ready_hold", cfg_ready, 0);
        wait_bit(b2);
        check_eq("t3_old_iv", b2 - b1, clamp(b2 - b1, 5208, 5209));
        check_eq("t3_ready_back", cfg_ready, 1);
        wait_bit(b3);
        check_eq("t3_new_iv0", b3 - b2, clamp(b3 - b2, 868, 869));
        wait_bit(b0);
        check_eq("t3_new_iv1", b0 - b3, clamp(b0 - b3, 868, 869));

        // unsupported rate falls back to 9600 with baud_err
        do_cfg(12345);
        wait_bit(b0);
        check_eq("t4_err_set", baud_err, 1);
        check_eq("t4_locked", locked, 1);
        wait_bit(b1);
        tick($urandom_range(100, 3000));
        do_cfg(19200);
        wait_bit(b2);
        check_eq("t4_default_iv", b2 - b1, clamp(b2 - b1, 5208, 5209));
        check_eq("t4_err_clr", baud_err, 0);
        wait_bit(b3);
        check_eq("t4_19200_iv", b3 - b2, clamp(b3 - b2, 2604, 2605));

        // back-to-back requests: second held until first applied
        baud = BAUD_W'(38400);
        cfg_valid = 1'b1;
        tick(1);
        baud = BAUD_W'(4800);
        tick(1);
        check_eq("t5_second_held", cfg_ready, 0);
        wait_bit(b0);
        check_eq("t5_first_applied", cfg_ready, 1);
        tick(1);
        check_eq("t5_second_pend", cfg_ready, 0);
        cfg_valid = 1'b0;
        wait_bit(b1);
        check_eq("t5_38400_iv", b1 - b0, clamp(b1 - b0, 1302, 1303));
        wait_bit(b2);
        check_eq("t5_4800_iv", b2 - b1, clamp(b2 - b1, 10408, 10417));

        // reset with a request pending, then restart from phase 0
        do_cfg(115200);
        tick($urandom_range(50, 500));
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        en = 1'b0;
        check_eq("t6_os_tick", os_tick, 0);
        check_eq("t6_bit_tick", bit_tick, 0);
        check_eq("t6_tx_clk", tx_clk, 0);
        check_eq("t6_locked", locked, 0);
        check_eq("t6_baud_err", baud_err, 0);
        check_eq("t6_cfg_ready", cfg_ready, 1);
        tick(20);
        check_eq("t6_pend_dropped", locked, 0);
        do_cfg(115200);
        tick(1);
        check_eq("t6_relock", locked, 1);
        exp_first = longint'((OSR * TWO_W + inc_of(115200) - 1)
                             / inc_of(115200));
        en = 1'b1;
        c0 = cyc;
        wait_bit(b0);
        check_eq("t6_first_bit", b0 - c0, exp_first);
        tick(3);
        check_eq("t6_tx_before_off", tx_clk, 1);
        en = 1'b0;
        tick(1);
        check_eq("t6_off_os", os_tick, 0);
        check_eq("t6_off_bit", bit_tick, 0);
        check_eq("t6_off_tx", tx_clk, 0);
        tick($urandom_range(2, 20));
        en = 1'b1;
        c0 = cyc;
        wait_bit(b0);
        check_eq("t6_restart_bit", b0 - c0, exp_first);

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
